count_display: RTL and testbench

Downstream display stage for the lab counter. It takes the 16-bit `count` and its `incremented` pulse from the counter, converts the value to BCD with a sequential double-dabble FSM, and drives a 4-digit multiplexed, common-anode seven-segment display. Values above 9999 show as dashes. The block runs on the same 100 MHz clock as the counter.

---
 rtl/seg_pkg.sv | 37 +++
 rtl/seg_decoder.sv | 33 +++
 rtl/count_display.sv | 155 +++++++++++++++
 tb/tb_count_display.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants for the count display: active-low segment patterns,
// conversion FSM encodings and the double-dabble nibble adjust step.
package seg_pkg;

   localparam int NUM_DIGITS = 4;

   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Add 3 to every nibble >= 5 so the following left shift carries correctly.
   function automatic logic [19:0] dd_adjust(input logic [19:0] bcd);
      logic [19:0] res;
      res = bcd;
      for (int i = 0; i < 5; i++) begin
         if (bcd[4*i +: 4] >= 4'd5)
            res[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
      return res;
   endfunction

endpackage

// File: rtl/seg_decoder.sv
// BCD digit to active-low seven-segment pattern; dash overrides blank,
// and blank overrides the decoded digit.
module seg_decoder
   import seg_pkg::*;
(
   input  logic [3:0] bcd_i,
   input  logic       blank_i,
   input  logic       dash_i,
   output logic [6:0] seg_o
);

   always_comb begin
      seg_o = SEG_BLANK;
      if (dash_i) begin
         seg_o = SEG_DASH;
      end else if (!blank_i) begin
         case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
         endcase
      end
   end

endmodule

// File: rtl/count_display.sv
// Converts the counter value to BCD with a sequential double-dabble FSM and
// scans it onto a 4-digit multiplexed common-anode seven-segment display.
module count_display
   import seg_pkg::*;
#(
   parameter int REFRESH_DIV = 100000,
   parameter bit BLANK_LZ    = 1'b0
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] count,
   input  logic        incremented,
   output logic [6:0]  seg,
   output logic        dp,
   output logic [3:0]  an,
   output logic        busy
);

   localparam int RW = $clog2(REFRESH_DIV);

   state_t        state_q, state_d;
   logic [15:0]   bin_q, bin_d;
   logic [19:0]   bcd_q, bcd_d;
   logic [3:0]    iter_q, iter_d;
   logic          ovf_cand_q, ovf_cand_d;
   logic          pending_q, pending_d;
   logic [15:0]   disp_q, disp_d;
   logic          ovf_q, ovf_d;
   logic          busy_q, busy_d;
   logic [RW-1:0] refresh_q;
   logic [1:0]    idx_q;
   logic [6:0]    seg_q;
   logic [3:0]    an_q;
   logic [35:0]   shift_w;

   assign shift_w = {dd_adjust(bcd_q), bin_q} << 1;

   always_comb begin
      state_d    = state_q;
      bin_d      = bin_q;
      bcd_d      = bcd_q;
      iter_d     = iter_q;
      ovf_cand_d = ovf_cand_q;
      pending_d  = pending_q;
      disp_d     = disp_q;
      ovf_d      = ovf_q;
      case (state_q)
         IDLE: begin
            if (incremented) begin
               bin_d      = count;
               bcd_d      = '0;
               ovf_cand_d = (count > 16'd9999);
               iter_d     = '0;
               state_d    = SHIFT;
            end
         end
         SHIFT: begin
            bcd_d  = shift_w[35:16];
            bin_d  = shift_w[15:0];
            iter_d = iter_q + 4'd1;
            if (incremented)
               pending_d = 1'b1;
            if (iter_q == 4'd15)
               state_d = DONE;
         end
         DONE: begin
            disp_d = bcd_q[15:0];
            ovf_d  = ovf_cand_q;
            // A strobe landing in DONE is folded into the pending reload.
            if (pending_q || incremented) begin
               pending_d  = 1'b0;
               bin_d      = count;
               bcd_d      = '0;
               ovf_cand_d = (count > 16'd9999);
               iter_d     = '0;
               state_d    = SHIFT;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         bin_q      <= '0;
         bcd_q      <= '0;
         iter_q     <= '0;
         ovf_cand_q <= 1'b0;
         pending_q  <= 1'b0;
         disp_q     <= '0;
         ovf_q      <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         bin_q      <= bin_d;
         bcd_q      <= bcd_d;
         iter_q     <= iter_d;
         ovf_cand_q <= ovf_cand_d;
         pending_q  <= pending_d;
         disp_q     <= disp_d;
         ovf_q      <= ovf_d;
         busy_q     <= busy_d;
      end
   end

   // lz[d] is set when digit d and every digit above it are zero.
   logic [NUM_DIGITS:0]   lz;
   logic [NUM_DIGITS-1:0] blank_vec;
   assign lz[NUM_DIGITS] = 1'b1;

   generate
      for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_lz
         assign lz[gi]        = (disp_q[4*gi +: 4] == 4'd0) && lz[gi+1];
         assign blank_vec[gi] = BLANK_LZ && (gi != 0) && lz[gi];
      end
   endgenerate

   logic [6:0] seg_w;

   seg_decoder u_dec (
      .bcd_i   (disp_q[{idx_q, 2'b00} +: 4]),
      .blank_i (blank_vec[idx_q]),
      .dash_i  (ovf_q),
      .seg_o   (seg_w)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         refresh_q <= '0;
         idx_q     <= '0;
         seg_q     <= SEG_BLANK;
         an_q      <= 4'b1111;
      end else begin
         if (refresh_q == RW'(REFRESH_DIV - 1)) begin
            refresh_q <= '0;
            idx_q     <= idx_q + 2'd1;
         end else begin
            refresh_q <= refresh_q + 1'b1;
         end
         seg_q <= seg_w;
         an_q  <= ~(4'b0001 << idx_q);
      end
   end

   assign seg  = seg_q;
   assign an   = an_q;
   assign busy = busy_q;
   assign dp   = 1'b1;

endmodule

// File: tb/tb_count_display.sv
// Directed bench for count_display: two instances (leading zeros shown /
// blanked) share stimulus; checks reset, scan order, conversions and overrides.
module tb_count_display;

   localparam logic [6:0] D0 = 7'b1000000, D1 = 7'b1111001, D2 = 7'b0100100;
   localparam logic [6:0] D3 = 7'b0110000, D4 = 7'b0011001, D5 = 7'b0010010;
   localparam logic [6:0] D7 = 7'b1111000, D9 = 7'b0010000;
   localparam logic [6:0] BL = 7'b1111111, DA = 7'b0111111;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] count;
   logic        incremented;
   logic [6:0]  seg0, seg1;
   logic        dp0, dp1, busy0, busy1;
   logic [3:0]  an0, an1;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   count_display #(.REFRESH_DIV(4), .BLANK_LZ(1'b0)) u_dut (
      .clk(clk), .rst(rst_n), .count(count), .incremented(incremented),
      .seg(seg0), .dp(dp0), .an(an0), .busy(busy0)
   );

   count_display #(.REFRESH_DIV(4), .BLANK_LZ(1'b1)) u_dut_lz (
      .clk(clk), .rst(rst_n), .count(count), .incremented(incremented),
      .seg(seg1), .dp(dp1), .an(an1), .busy(busy1)
   );

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [3:0] an_of(input bit sel);
      return sel ? an1 : an0;
   endfunction

   function automatic logic [6:0] seg_of(input bit sel);
      return sel ? seg1 : seg0;
   endfunction

   // Strobe one value and return how many cycles busy stays high.
   task automatic convert(input logic [15:0] v, output int n);
      @(negedge clk);
      count = v;
      incremented = 1'b1;
      @(negedge clk);
      incremented = 1'b0;
      n = 0;
      while (busy0 && n < 200) begin
         n++;
         @(negedge clk);
      end
      @(negedge clk);
      $display("convert count=%0d busy_cycles=%0d", v, n);
   endtask

   // Wait for each anode in turn (bounded) and compare its segment pattern.
   task automatic show(input string tag, input bit sel,
                       input logic [6:0] e3, input logic [6:0] e2,
                       input logic [6:0] e1, input logic [6:0] e0);
      logic [6:0] exp_seg [4];
      exp_seg[0] = e0; exp_seg[1] = e1; exp_seg[2] = e2; exp_seg[3] = e3;
      for (int d = 0; d < 4; d++) begin
         logic [3:0] want;
         int t;
         want = ~(4'b0001 << d);
         t = 0;
         while (an_of(sel) !== want && t < 40) begin
            @(negedge clk);
            t++;
         end
         check($sformatf("%s_an%0d", tag, d), {12'd0, an_of(sel)}, {12'd0, want});
         check($sformatf("%s_seg%0d", tag, d), {9'd0, seg_of(sel)}, {9'd0, exp_seg[d]});
      end
      $display("display %s checked on instance %0d", tag, sel);
   endtask

   initial begin
      int n;
      rst_n = 1'b0;
      count = '0;
      incremented = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_an",   {12'd0, an0},  16'h000F);
      check("rst_seg",  {9'd0, seg0},  {9'd0, BL});
      check("rst_busy", {15'd0, busy0}, 16'd0);
      check("rst_dp",   {15'd0, dp0},  16'd1);
      check("rst_an_lz", {12'd0, an1}, 16'h000F);
      $display("reset held: an=%b seg=%b busy=%b", an0, seg0, busy0);

      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 16; k++) begin
         logic [3:0] want;
         @(negedge clk);
         want = ~(4'b0001 << (k / 4));
         check($sformatf("scan_an_c%0d", k), {12'd0, an0}, {12'd0, want});
         check($sformatf("scan_seg_c%0d", k), {9'd0, seg0}, {9'd0, D0});
      end
      $display("scan after reset checked over 16 cycles");

      convert(16'd1234, n);
      check("busy_1234", n[15:0], 16'd17);
      show("v1234", 1'b0, D1, D2, D3, D4);

      convert(16'd9999, n);
      check("busy_9999", n[15:0], 16'd17);
      show("v9999", 1'b0, D9, D9, D9, D9);

      convert(16'd10000, n);
      show("v10000", 1'b0, DA, DA, DA, DA);

      convert(16'd65535, n);
      show("v65535", 1'b0, DA, DA, DA, DA);
      show("v65535_lz", 1'b1, DA, DA, DA, DA);

      convert(16'd7, n);
      show("v7_lz", 1'b1, BL, BL, BL, D7);
      show("v7", 1'b0, D0, D0, D0, D7);

      convert(16'd0, n);
      show("v0_lz", 1'b1, BL, BL, BL, D0);

      convert(16'd1005, n);
      show("v1005_lz", 1'b1, D1, D0, D0, D5);

      // Second strobe 5 cycles after the first lands during SHIFT.
      @(negedge clk);
      count = 16'd5;
      incremented = 1'b1;
      @(negedge clk);
      incremented = 1'b0;
      n = 0;
      for (int k = 0; k < 60; k++) begin
         if (busy0) n++;
         if (k == 4) begin
            count = 16'd42;
            incremented = 1'b1;
         end
         if (k == 5) incremented = 1'b0;
         @(negedge clk);
      end
      $display("pending reload 5 then 42 busy_cycles=%0d", n);
      check("busy_pending", n[15:0], 16'd34);
      show("v42", 1'b0, D0, D0, D4, D2);

      // Reset 8 cycles into a conversion of 8888.
      @(negedge clk);
      count = 16'd8888;
      incremented = 1'b1;
      @(negedge clk);
      incremented = 1'b0;
      repeat (7) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_an",   {12'd0, an0},  16'h000F);
      check("midrst_seg",  {9'd0, seg0},  {9'd0, BL});
      check("midrst_busy", {15'd0, busy0}, 16'd0);
      $display("reset mid-conversion: an=%b seg=%b busy=%b", an0, seg0, busy0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("postrst_busy", {15'd0, busy0}, 16'd0);
      show("postrst", 1'b0, D0, D0, D0, D0);
      check("postrst_busy2", {15'd0, busy0}, 16'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
